// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the access FSM encoding, the wait-counter width and the word-index width helper.
// Pure declarations; no logic, so no latency or backpressure of its own.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    COMPLETE = 2'd2
  } dmem_state_t;

  localparam int WAIT_W = 4;

  // Number of address bits needed to select one word out of depth_words.
  function automatic int word_idx_w(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage with per-byte write enables.
// Latency: read is combinational, write lands on the rising edge.
// Backpressure: none; the caller decides when a write commits.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                               clk,
  input  logic                               we_i,
  input  logic [3:0]                         be_i,
  input  logic [word_idx_w(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                        wdata_i,
  output logic [31:0]                        rdata_o
);

  // Contents are deliberately not reset; they survive a core reset.
  logic [31:0] mem_q [DEPTH_WORDS];

  // Byte-lane write: only enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: serves loads/stores after WAIT_STATES stall cycles.
// Latency: WAIT_STATES+1 cycles per access; back-to-back accesses with no idle bubble.
// Backpressure: MemStallM holds the core until the access reaches its completion cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] TOHOST_ADDR = 32'd96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] DataAdrM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  ByteEnM,
  output logic [31:0] ReadDataM,
  output logic        MemStallM,
  output logic        done,
  output logic [31:0] done_code,
  output logic        err
);

  localparam int                IW    = word_idx_w(DEPTH_WORDS);
  localparam logic [WAIT_W-1:0] WS    = WAIT_W'(WAIT_STATES);
  localparam logic [32:0]       LIMIT = 33'(4 * DEPTH_WORDS);

  dmem_state_t       state;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              req;
  logic              in_range;
  logic              stall;
  logic              commit;
  logic              mem_we;
  logic              tohost_hit;
  logic              changed;
  logic [IW-1:0]     widx;
  logic [31:0]       rdata;

  logic              done_q, done_d;
  logic [31:0]       code_q, code_d;
  logic              err_q, err_d;
  logic              stall_q;
  logic [31:0]       adr_q;
  logic              wr_q;
  logic [31:0]       wd_q;

  assign req      = MemReadM | MemWriteM;
  assign in_range = ({1'b0, DataAdrM} < LIMIT);
  assign widx     = DataAdrM[IW+1:2];

  // Access FSM: state is decoded from the live request and the wait counter.
  // Reset masks stall/commit so an in-flight access neither holds the core nor writes.
  always_comb begin
    state  = IDLE;
    cnt_d  = '0;
    stall  = 1'b0;
    commit = 1'b0;
    if (req) begin
      state = (cnt_q == WS) ? COMPLETE : BUSY;
    end
    case (state)
      IDLE: begin
        cnt_d = '0;
      end
      BUSY: begin
        cnt_d = cnt_q + WAIT_W'(1);
        stall = ~reset;
      end
      COMPLETE: begin
        cnt_d  = '0;
        commit = ~reset;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Wait counter; a dropped request (flush) falls back to IDLE and clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A simultaneous read+write is treated as a store, so only MemWriteM steers the write.
  assign mem_we     = commit & MemWriteM & in_range;
  assign tohost_hit = commit & MemWriteM & (DataAdrM == TOHOST_ADDR)
                    & (ByteEnM == 4'hF) & ~done_q;

  // Any change of address, write flag or store data between stalled cycles of one access.
  assign changed = stall_q & req &
                   ((DataAdrM != adr_q) | (MemWriteM != wr_q) | (WriteDataM != wd_q));

  // Sticky completion and protocol-error flags; only the first tohost store is recorded.
  always_comb begin
    done_d = done_q;
    code_d = code_q;
    err_d  = err_q;
    if (tohost_hit) begin
      done_d = 1'b1;
      code_d = WriteDataM;
    end
    if ((req & MemReadM & MemWriteM) | changed) begin
      err_d = 1'b1;
    end
  end

  // Flag registers plus a one-cycle history of the request used for change detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q  <= 1'b0;
      code_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      adr_q   <= '0;
      wr_q    <= 1'b0;
      wd_q    <= '0;
    end else begin
      done_q  <= done_d;
      code_q  <= code_d;
      err_q   <= err_d;
      stall_q <= stall;
      adr_q   <= DataAdrM;
      wr_q    <= MemWriteM;
      wd_q    <= WriteDataM;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .we_i   (mem_we),
    .be_i   (ByteEnM),
    .addr_i (widx),
    .wdata_i(WriteDataM),
    .rdata_o(rdata)
  );

  // Load data is only driven in the completion cycle of an in-range pure load.
  assign ReadDataM = (state == COMPLETE && MemReadM && !MemWriteM && in_range) ? rdata : 32'h0;
  assign MemStallM = stall;
  assign done      = done_q;
  assign done_code = code_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance with 2 wait states, one with none.
// Expected values come from a word-array model updated per completed access.
// Each task drives its own scenario and compares inline.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: WAIT_STATES=2
  logic        a_rd, a_wr, a_stall, a_done, a_err;
  logic [31:0] a_adr, a_wd, a_rdata, a_code;
  logic [3:0]  a_be;
  // Instance B: WAIT_STATES=0
  logic        b_rd, b_wr, b_stall, b_done, b_err;
  logic [31:0] b_adr, b_wd, b_rdata, b_code;
  logic [3:0]  b_be;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .TOHOST_ADDR(32'd96)) u_a (
    .clk(clk), .reset(rst), .MemReadM(a_rd), .MemWriteM(a_wr), .DataAdrM(a_adr),
    .WriteDataM(a_wd), .ByteEnM(a_be), .ReadDataM(a_rdata), .MemStallM(a_stall),
    .done(a_done), .done_code(a_code), .err(a_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .TOHOST_ADDR(32'd96)) u_b (
    .clk(clk), .reset(rst), .MemReadM(b_rd), .MemWriteM(b_wr), .DataAdrM(b_adr),
    .WriteDataM(b_wd), .ByteEnM(b_be), .ReadDataM(b_rdata), .MemStallM(b_stall),
    .done(b_done), .done_code(b_code), .err(b_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents as seen by each instance.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) if (be[l]) r[8*l +: 8] = wd[8*l +: 8];
    return r;
  endfunction

  // Drive one access on instance sel (0=A, 1=B), hold it until stall drops, and
  // report the number of stalled cycles and the data seen in the completion cycle.
  task automatic acc(input bit sel, input logic rd, input logic wr, input logic [31:0] adr,
                     input logic [31:0] wd, input logic [3:0] be,
                     output int nstall, output logic [31:0] rdata);
    logic st;
    if (sel == 1'b0) begin a_rd = rd; a_wr = wr; a_adr = adr; a_wd = wd; a_be = be; end
    else             begin b_rd = rd; b_wr = wr; b_adr = adr; b_wd = wd; b_be = be; end
    nstall = 0;
    rdata  = 32'hDEAD_BEEF;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      st = sel ? b_stall : a_stall;
      if (!st) begin
        rdata = sel ? b_rdata : a_rdata;
        break;
      end
      nstall++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (rd || wr) begin
      if (adr < 32'd1024 && wr) begin
        if (sel == 1'b0) mem_a[adr[9:2]] = merge(mem_a[adr[9:2]], wd, be);
        else             mem_b[adr[9:2]] = merge(mem_b[adr[9:2]], wd, be);
      end
    end
  endtask

  task automatic idle();
    a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    a_rd = 0; a_wr = 0; a_adr = 0; a_wd = 0; a_be = 0;
    b_rd = 0; b_wr = 0; b_adr = 0; b_wd = 0; b_be = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", a_stall); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", a_rdata); end
    checks++; if (a_done !== 1'b0 || a_err !== 1'b0) begin errors++; $display("FAIL reset_flags done=%b err=%b want 0 0", a_done, a_err); end
    checks++; if (a_code !== 32'h0) begin errors++; $display("FAIL reset_code got %h want 0", a_code); end
    checks++; if (u_a.cnt_q !== 4'd0 || u_b.cnt_q !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0", u_a.cnt_q, u_b.cnt_q); end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic preload();
    int n; logic [31:0] r;
    for (int i = 0; i < 256; i++) begin
      if (i != 24) acc(0, 0, 1, 32'(i * 4), $urandom, 4'hF, n, r);
    end
    for (int i = 0; i < 4; i++) acc(1, 0, 1, 32'(i * 4), $urandom, 4'hF, n, r);
    idle();
  endtask

  task automatic test_store_load();
    int n; logic [31:0] r;
    acc(0, 0, 1, 32'h10, 32'h0000_00AA, 4'hF, n, r);
    checks++; if (n != 2) begin errors++; $display("FAIL store_stall got %0d want 2", n); end
    acc(0, 1, 0, 32'h10, 32'h0, 4'h0, n, r);
    checks++; if (n != 2) begin errors++; $display("FAIL load_stall got %0d want 2", n); end
    checks++; if (r !== 32'hAA) begin errors++; $display("FAIL load_data got %h want 000000aa", r); end
    idle();
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL idle_rdata got %h want 0", a_rdata); end
  endtask

  task automatic test_byte_store();
    int n; logic [31:0] r;
    acc(0, 0, 1, 32'h10, 32'h1122_3344, 4'hF, n, r);
    acc(0, 0, 1, 32'h11, 32'h0000_5500, 4'b0010, n, r);
    acc(0, 1, 0, 32'h10, 32'h0, 4'h0, n, r);
    checks++; if (r !== 32'h1122_5544) begin errors++; $display("FAIL byte_store got %h want 11225544", r); end
    idle();
  endtask

  task automatic test_tohost();
    int n; logic [31:0] r;
    acc(0, 0, 1, 32'd96, 32'd3, 4'hF, n, r);
    checks++; if (a_done !== 1'b1 || a_code !== 32'd3) begin errors++; $display("FAIL tohost_first done=%b code=%h want 1 3", a_done, a_code); end
    acc(0, 0, 1, 32'd96, 32'd7, 4'hF, n, r);
    checks++; if (a_done !== 1'b1 || a_code !== 32'd3) begin errors++; $display("FAIL tohost_second done=%b code=%h want 1 3", a_done, a_code); end
    acc(0, 1, 0, 32'd96, 32'h0, 4'h0, n, r);
    checks++; if (r !== 32'd7) begin errors++; $display("FAIL tohost_storage got %h want 7", r); end
    idle();
  endtask

  task automatic test_ws0_back_to_back();
    int n; logic [31:0] r;
    for (int i = 0; i < 3; i++) begin
      acc(1, 1, 0, 32'(i * 4), 32'h0, 4'h0, n, r);
      checks++; if (n != 0) begin errors++; $display("FAIL ws0_stall[%0d] got %0d want 0", i, n); end
      checks++; if (r !== mem_b[i]) begin errors++; $display("FAIL ws0_data[%0d] got %h want %h", i, r, mem_b[i]); end
    end
    idle();
    checks++; if (b_err !== 1'b0 || b_done !== 1'b0) begin errors++; $display("FAIL ws0_flags err=%b done=%b want 0 0", b_err, b_done); end
  endtask

  task automatic test_flush();
    int n; logic [31:0] r;
    a_rd = 0; a_wr = 1; a_adr = 32'h40; a_wd = ~mem_a[16]; a_be = 4'hF;
    @(negedge clk);
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL flush_stall got %b want 1", a_stall); end
    @(posedge clk); #1;
    idle();
    idle();
    acc(0, 1, 0, 32'h40, 32'h0, 4'h0, n, r);
    checks++; if (r !== mem_a[16]) begin errors++; $display("FAIL flush_mem got %h want %h", r, mem_a[16]); end
    idle();
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL flush_err got %b want 0", a_err); end
  endtask

  task automatic test_random();
    int n; logic [31:0] r, adr, exp; bit rd, oor;
    for (int t = 0; t < 60; t++) begin
      rd  = $urandom_range(0, 1) == 1;
      oor = $urandom_range(0, 7) == 0;
      adr = oor ? 32'($urandom_range(1024, 4095)) : 32'($urandom_range(0, 1023));
      exp = oor ? 32'h0 : mem_a[adr[9:2]];
      acc(0, rd, !rd, adr, $urandom, 4'($urandom_range(0, 15)), n, r);
      checks++; if (n != 2) begin errors++; $display("FAIL rand_stall[%0d] got %0d want 2", t, n); end
      if (rd) begin
        checks++; if (r !== exp) begin errors++; $display("FAIL rand_load[%0d] adr=%h got %h want %h", t, adr, r, exp); end
      end
    end
    idle();
    checks++; if (a_err !== 1'b0 || a_code !== 32'd3) begin errors++; $display("FAIL rand_flags err=%b code=%h want 0 3", a_err, a_code); end
  endtask

  task automatic test_addr_change();
    int n; logic [31:0] r, d;
    d = 32'hC0DE_0024;
    a_rd = 0; a_wr = 1; a_adr = 32'h20; a_wd = d; a_be = 4'hF;
    @(posedge clk); #1;
    a_adr = 32'h24;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL chg_complete stall=%b want 0", a_stall); end
    @(posedge clk); #1;
    mem_a[9] = d;
    idle();
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL chg_err got %b want 1", a_err); end
    acc(0, 1, 0, 32'h24, 32'h0, 4'h0, n, r);
    checks++; if (r !== d) begin errors++; $display("FAIL chg_new got %h want %h", r, d); end
    acc(0, 1, 0, 32'h20, 32'h0, 4'h0, n, r);
    checks++; if (r !== mem_a[8]) begin errors++; $display("FAIL chg_old got %h want %h", r, mem_a[8]); end
    idle();
  endtask

  task automatic test_reset_mid();
    int n; logic [31:0] r;
    a_rd = 0; a_wr = 1; a_adr = 32'h30; a_wd = ~mem_a[12]; a_be = 4'hF;
    @(posedge clk); #1;
    rst = 1;
    #1;
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b want 0", a_stall); end
    checks++; if (u_a.cnt_q !== 4'd0) begin errors++; $display("FAIL rstmid_cnt got %0d want 0", u_a.cnt_q); end
    checks++; if (a_done !== 1'b0 || a_err !== 1'b0) begin errors++; $display("FAIL rstmid_flags done=%b err=%b want 0 0", a_done, a_err); end
    a_wr = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    acc(0, 1, 0, 32'h30, 32'h0, 4'h0, n, r);
    checks++; if (r !== mem_a[12]) begin errors++; $display("FAIL rstmid_mem got %h want %h", r, mem_a[12]); end
    idle();
  endtask

  initial begin
    test_reset();
    preload();
    test_store_load();
    test_byte_store();
    test_tohost();
    test_ws0_back_to_back();
    test_flush();
    test_random();
    test_addr_change();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32IC pipeline's M-stage load/store port: the memory-side end of the core's `MemWrite`/`DataAdr`/`WriteData`/`ReadData` interface. Services each load and store after a programmable number of wait states. Holds the core with a stall signal until each access completes. Exposes a sticky "tohost" completion register so benches and SoC glue detect program end from one flag.

## Interface
- `DEPTH_WORDS`, 256, number of 32-bit words backed by storage (power of two)
- `WAIT_STATES`, 2, stall cycles inserted before each access completes (0..15)
- `TOHOST_ADDR`, 32'd96, byte address of the completion register
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `MemReadM`  in  1  load request
- `MemWriteM`  in  1  store request
- `DataAdrM`  in  32  byte address; bits [1:0] ignored for word select
- `WriteDataM`  in  32  store data, byte lanes already aligned by the core
- `ByteEnM`  in  4  store byte enables; bit i covers bits [8i+7:8i]
- `ReadDataM`  out  32  load data, valid only in the completion cycle
- `MemStallM`  out  1  high while the current access is not yet complete
- `done`  out  1  sticky; set by a full-word store to TOHOST_ADDR
- `done_code`  out  32  data of the first such store
- `err`  out  1  sticky protocol-error flag

## Operation
- Request present when `MemReadM | MemWriteM`. Wait counter `cnt` (4 bits) is 0 when idle.
- FSM states: IDLE (cnt==0, no request), BUSY (request held, cnt<WAIT_STATES), COMPLETE (request held, cnt==WAIT_STATES).
- `MemStallM = req && (cnt != WAIT_STATES)`, combinational.
- Each edge with stall high: cnt increments. Edge ending COMPLETE: cnt returns to 0.
- Store commit happens on the edge ending COMPLETE. Only enabled byte lanes are written.
- Load: `ReadDataM` = storage word during COMPLETE, else 32'h0.
- Word index = `DataAdrM[$clog2(DEPTH_WORDS)+1:2]`.
- Out of range (address ≥ 4*DEPTH_WORDS): stores dropped, loads return 0, timing unchanged, no error.
- Tohost store (address == TOHOST_ADDR, `ByteEnM`==4'hF, done low): sets `done` and loads `done_code` at commit. The store also writes storage. Later tohost stores leave `done_code` unchanged.
- Error conditions, each setting `err` and never clearing it except by reset:
  - `MemReadM & MemWriteM` together: access is treated as a store.
  - `DataAdrM`, `MemWriteM` or `WriteDataM` changes while stalled: the value present at completion is used.
- Request drops mid-wait (pipeline flush): cnt returns to 0 next edge. No store is committed. Not an error.
- Storage is not reset. Initial contents come from the bench via hierarchical `$readmemh`.

## Timing
- Reset values:
  - cnt=0, `done`=0, `done_code`=0, `err`=0.
  - `ReadDataM`=0 and `MemStallM`=0 while no request.
- Access latency is WAIT_STATES+1 cycles. With WAIT_STATES=2, a request in cycle 0:
  - stall high in cycles 0 and 1;
  - stall low and load data valid in cycle 2;
  - store commits at the end of cycle 2.
- WAIT_STATES=0: stall never asserts. Every access completes in its first cycle.
- Back-to-back requests: the next request is accepted in the cycle after COMPLETE. There is no idle bubble.
- Load of an address stored in the previous access returns the new data.
- Reset asserted mid-access: cnt=0 immediately and the pending store is lost. Storage written before reset is retained.

## Structure
- Package `dmem_pkg`:
  - `dmem_state_t` enum {IDLE, BUSY, COMPLETE};
  - `WAIT_W`=4;
  - function `word_idx_w(DEPTH_WORDS)`.
- Sub-module `dmem_array`: DEPTH_WORDS×32 storage, combinational read, byte-enable synchronous write.
- Top holds the FSM, counter, tohost and error logic.

## Test plan
- WAIT_STATES=2:
  - store 32'h0000_00AA to 0x10 with BE=F, then load 0x10 -> stall high 2 cycles per access, ReadDataM=32'hAA in load's third cycle;
  - byte store 8'h55 to 0x11 with BE=4'b0010 over word 32'h1122_3344 -> load 0x10 returns 32'h1122_5544;
  - full-word store of 3 to address 96 -> `done`=1 and `done_code`=3 after commit; a second store of 7 leaves `done_code`=3.
- WAIT_STATES=0, loads back-to-back at 0x0, 0x4, 0x8 -> stall never high, one word per cycle.
- Faults, each checked separately:
  - store with request dropped after 1 stall cycle -> memory unchanged, `err`=0;
  - address changed from 0x20 to 0x24 while stalled -> `err`=1, write lands at 0x24.
- Reset asserted in a BUSY cycle of a store -> stall low, cnt=0, target word unchanged, `done`/`err` cleared.
